// File: rtl/pdu_pkg.sv
// rtl/pdu_pkg.sv - shared types and constants for the PDU input controller
package pdu_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } pdu_state_e;

    localparam int DIG_MAX    = 8;
    localparam int SYNC_DEPTH = 2;
    localparam int DB_CYCLES  = 8;

    // Index of the set bit of a one-hot digit vector (0 when empty)
    function automatic logic [3:0] onehot_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pdu_edge_sync.sv
// rtl/pdu_edge_sync.sv - input synchroniser, optional PDU_DEBOUNCE_EN filter, registered rising-edge pulse
module pdu_edge_sync
    import pdu_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [SYNC_DEPTH-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0] lvl;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] rise_q, rise_d;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_DEPTH; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef PDU_DEBOUNCE_EN
    logic [W-1:0]      filt_q, filt_d;
    logic [W-1:0][3:0] cnt_q, cnt_d;

    // The filtered level follows the raw level only after it has disagreed for DB_CYCLES cycles in a row
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < W; i++) begin
            if (sync_q[SYNC_DEPTH-1][i] == filt_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == 4'(DB_CYCLES - 1)) begin
                filt_d[i] = sync_q[SYNC_DEPTH-1][i];
                cnt_d[i]  = 4'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_DEPTH-1];
`endif

    always_comb begin
        prev_d = lvl;
        rise_d = lvl & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pdu_input_ctrl.sv
// rtl/pdu_input_ctrl.sv - board input front end: hex entry, CPU I/O handshake, run control (PDU_DEBOUNCE_EN selects input filtering)
module pdu_input_ctrl
    import pdu_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   hd,
    input  logic          ent,
    input  logic          chk,
    input  logic          step,
    input  logic          cont,
    input  logic          cpu_halt,
    input  logic          in_rdy,
    output logic          cpu_en,
    output logic [DW-1:0] in_data,
    output logic          in_vld,
    output logic [7:0]    chk_addr,
    output logic [DW-1:0] buf_out,
    output logic [3:0]    dig_cnt,
    output logic          err,
    output logic [CW-1:0] cyc_cnt
);

    logic [15:0] hd_rise;
    logic [1:0]  btn_rise;
    logic        ent_e, step_e, multi_dig, any_dig;

    logic [SYNC_DEPTH-1:0][1:0] lvl_q, lvl_d;
    logic                       chk_s, cont_s;

    pdu_state_e    state_q, state_d;
    logic [DW-1:0] buf_q, buf_d, in_data_q, in_data_d;
    logic [3:0]    dig_cnt_q, dig_cnt_d;
    logic [7:0]    chk_addr_q, chk_addr_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic          in_vld_q, in_vld_d, err_q, err_d, cpu_en_q, cpu_en_d;

    pdu_edge_sync #(.W(16)) u_hd_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (hd),
        .rise (hd_rise)
    );

    pdu_edge_sync #(.W(2)) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  ({ent, step}),
        .rise (btn_rise)
    );

    assign ent_e     = btn_rise[1];
    assign step_e    = btn_rise[0];
    assign any_dig   = |hd_rise;
    assign multi_dig = |(hd_rise & (hd_rise - 16'd1));
    assign chk_s     = lvl_q[SYNC_DEPTH-1][1];
    assign cont_s    = lvl_q[SYNC_DEPTH-1][0];

    always_comb begin
        lvl_d[0] = {chk, cont};
        for (int i = 1; i < SYNC_DEPTH; i++) begin
            lvl_d[i] = lvl_q[i-1];
        end

        buf_d      = buf_q;
        dig_cnt_d  = dig_cnt_q;
        in_data_d  = in_data_q;
        in_vld_d   = in_vld_q;
        chk_addr_d = chk_addr_q;
        err_d      = 1'b0;

        if (in_vld_q && in_rdy) begin
            in_vld_d = 1'b0;
        end

        // A commit always sees the buffer as it was; a digit arriving with it is lost
        if (ent_e) begin
            if (chk_s) begin
                chk_addr_d = buf_q[7:0];
                buf_d      = '0;
                dig_cnt_d  = 4'd0;
            end else if (!in_vld_q) begin
                in_data_d = buf_q;
                in_vld_d  = 1'b1;
                buf_d     = '0;
                dig_cnt_d = 4'd0;
            end else begin
                err_d = 1'b1;
            end
            if (any_dig) begin
                err_d = 1'b1;
            end
        end else if (any_dig) begin
            if (multi_dig) begin
                err_d = 1'b1;
            end else begin
                buf_d = {buf_q[DW-5:0], onehot_idx(hd_rise)};
                if (dig_cnt_q < 4'(DIG_MAX)) begin
                    dig_cnt_d = dig_cnt_q + 4'd1;
                end
            end
        end

        state_d = state_q;
        case (state_q)
            HALT: begin
                if (step_e && !chk_s) begin
                    state_d = STEP;
                end else if (cont_s && !chk_s && !cpu_halt) begin
                    state_d = RUN;
                end
            end
            STEP:    state_d = HALT;
            RUN: begin
                if (chk_s || !cont_s || cpu_halt) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase

        cpu_en_d  = (state_d != HALT);
        cyc_cnt_d = cpu_en_q ? cyc_cnt_q + CW'(1) : cyc_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= '0;
            state_q    <= HALT;
            buf_q      <= '0;
            dig_cnt_q  <= '0;
            in_data_q  <= '0;
            in_vld_q   <= 1'b0;
            chk_addr_q <= '0;
            err_q      <= 1'b0;
            cpu_en_q   <= 1'b0;
            cyc_cnt_q  <= '0;
        end else begin
            lvl_q      <= lvl_d;
            state_q    <= state_d;
            buf_q      <= buf_d;
            dig_cnt_q  <= dig_cnt_d;
            in_data_q  <= in_data_d;
            in_vld_q   <= in_vld_d;
            chk_addr_q <= chk_addr_d;
            err_q      <= err_d;
            cpu_en_q   <= cpu_en_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    assign cpu_en   = cpu_en_q;
    assign in_data  = in_data_q;
    assign in_vld   = in_vld_q;
    assign chk_addr = chk_addr_q;
    assign buf_out  = buf_q;
    assign dig_cnt  = dig_cnt_q;
    assign err      = err_q;
    assign cyc_cnt  = cyc_cnt_q;

endmodule
